axi_lite_initiator: RTL and testbench

Single-outstanding AXI4-lite initiator: converts a simple valid/ready word-request port (read or write, 32-bit address/data, byte strobes) into AXI4-lite AR/R or AW/W/B transactions and returns one response per request. It is the host-side counterpart of the simulation memory responder and drives its `mem_axi_*` port set directly, so CPU stand-ins, DMA test drivers and switchboard-fed stimulus can issue memory and MMIO traffic.

---
 rtl/axi_lite_initiator.sv | 194 +++++++++++++++++++
 tb/tb_axi_lite_initiator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-lite initiator: one valid/ready word request in, one AR/R or AW/W/B transaction out, one response back.
// Optional watchdog enabled by defining AXI_LITE_INITIATOR_TIMEOUT_EN.
module axi_lite_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_insn,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  assign aw_hs          = mem_axi_awvalid & mem_axi_awready;
  assign w_hs           = mem_axi_wvalid & mem_axi_wready;
  assign mem_axi_awprot = 3'b000;

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             progress;
  logic             busy;

  // Sticky compare: a handshake at the limit defers the error to the next stalled cycle.
  assign tmo_hit = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign busy    = (state == RD_ADDR) || (state == RD_DATA) || (state == WR_REQ) || (state == WR_RESP);

  always_comb begin
    progress = 1'b0;
    case (state)
      RD_ADDR: progress = mem_axi_arready;
      RD_DATA: progress = mem_axi_rvalid;
      WR_REQ:  progress = aw_hs | w_hs;
      WR_RESP: progress = mem_axi_bvalid;
      default: progress = 1'b0;
    endcase
  end
`else
  logic tmo_unused;

  assign tmo_unused = (TIMEOUT_CYCLES > 0);
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_write       <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_awaddr  <= '0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_araddr  <= '0;
      mem_axi_arprot  <= '0;
      mem_axi_rready  <= 1'b0;
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
      tmo_cnt         <= '0;
      rsp_err         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            rsp_write <= req_write;
            if (req_write) begin
              mem_axi_awaddr  <= req_addr;
              mem_axi_wdata   <= req_wdata;
              mem_axi_wstrb   <= req_wstrb;
              mem_axi_awvalid <= 1'b1;
              mem_axi_wvalid  <= 1'b1;
              aw_done         <= 1'b0;
              w_done          <= 1'b0;
              state           <= WR_REQ;
            end else begin
              mem_axi_araddr  <= req_addr;
              mem_axi_arprot  <= {req_insn, 2'b00};
              mem_axi_arvalid <= 1'b1;
              state           <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (mem_axi_arready) begin
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b1;
            state           <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_axi_rvalid) begin
            mem_axi_rready <= 1'b0;
            rsp_rdata      <= mem_axi_rdata;
            rsp_valid      <= 1'b1;
            state          <= RSP;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave once both have been accepted.
          if (aw_hs) mem_axi_awvalid <= 1'b0;
          if (w_hs)  mem_axi_wvalid  <= 1'b0;
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            mem_axi_bready <= 1'b1;
            state          <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (mem_axi_bvalid) begin
            mem_axi_bready <= 1'b0;
            rsp_rdata      <= '0;
            rsp_valid      <= 1'b1;
            state          <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_hit && !progress) begin
          mem_axi_awvalid <= 1'b0;
          mem_axi_wvalid  <= 1'b0;
          mem_axi_bready  <= 1'b0;
          mem_axi_arvalid <= 1'b0;
          mem_axi_rready  <= 1'b0;
          rsp_rdata       <= 32'hDEAD_BEEF;
          rsp_err         <= 1'b1;
          rsp_valid       <= 1'b1;
          state           <= RSP;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Randomized self-checking bench for axi_lite_initiator: bench-side AXI memory responder plus a transaction-level scoreboard.
module tb_axi_lite_initiator;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_insn = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_err;
  logic        mem_axi_awvalid, mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  axi_lite_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_insn(req_insn),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Responder configuration and storage
  bit          rand_dly = 1'b0;
  bit          b_never = 1'b0;
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  function automatic int pick(input int d);
    return rand_dly ? int'($urandom_range(0, 3)) : d;
  endfunction

  // AXI memory responder: decides its inputs at negedge for the coming posedge
  initial begin
    int awc, wc, bc, arc, rc;
    bit aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_a, w_d, r_a, old;
    logic [3:0]  w_s;
    awc = -1; wc = -1; arc = -1; bc = 0; rc = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_a = '0; w_d = '0; r_a = '0; w_s = '0;
    mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_bvalid = 0;
    mem_axi_arready = 0; mem_axi_rvalid = 0; mem_axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awc = -1; wc = -1; arc = -1; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_bvalid = 0;
        mem_axi_arready = 0; mem_axi_rvalid = 0;
      end else begin
        mem_axi_awready = 0;
        if (mem_axi_awvalid && !aw_got) begin
          if (awc < 0) awc = pick(aw_dly);
          if (awc == 0) begin mem_axi_awready = 1; aw_got = 1; aw_a = mem_axi_awaddr; awc = -1; end
          else awc--;
        end
        mem_axi_wready = 0;
        if (mem_axi_wvalid && !w_got) begin
          if (wc < 0) wc = pick(w_dly);
          if (wc == 0) begin mem_axi_wready = 1; w_got = 1; w_d = mem_axi_wdata; w_s = mem_axi_wstrb; wc = -1; end
          else wc--;
        end
        if (aw_got && w_got && !b_pend) begin
          old = rmem.exists(aw_a) ? rmem[aw_a] : init_word(aw_a);
          rmem[aw_a] = merge(old, w_d, w_s);
          aw_got = 0; w_got = 0; b_pend = 1; bc = pick(b_dly);
        end
        mem_axi_bvalid = 0;
        if (b_pend && !b_never) begin
          if (bc > 0) bc--;
          else begin mem_axi_bvalid = 1; if (mem_axi_bready) b_pend = 0; end
        end
        mem_axi_arready = 0;
        if (mem_axi_arvalid && !r_pend) begin
          if (arc < 0) arc = pick(ar_dly);
          if (arc == 0) begin mem_axi_arready = 1; r_pend = 1; r_a = mem_axi_araddr; rc = pick(r_dly); arc = -1; end
          else arc--;
        end
        mem_axi_rvalid = 0;
        if (r_pend) begin
          if (rc > 0) rc--;
          else begin
            mem_axi_rvalid = 1;
            mem_axi_rdata = rmem.exists(r_a) ? rmem[r_a] : init_word(r_a);
            if (mem_axi_rready) r_pend = 0;
          end
        end
      end
    end
  end

  // Scoreboard and per-cycle compare
  typedef struct {
    logic        w;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  bit          expect_tmo = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  logic [3:0]  cur_strb = '0;
  logic        cur_insn = 1'b0;
  int          ncyc = 0;
  int          t_acc = 0, t_ar = -1, t_rr = -1, t_aw_last = -1, t_w_last = -1, t_b = -1, t_b_last = -1, t_rsp = -1, rsp_cycles = 0;
  logic [31:0] last_rdata = '0;
  logic        last_write = 1'b0, last_err = 1'b0;
  logic [2:0]  last_arprot = '0;

  initial begin
    bit prev_rst, p_ar_stall, p_aw_stall, p_w_stall;
    exp_t e;
    logic [31:0] old;
    prev_rst = 1; p_ar_stall = 0; p_aw_stall = 0; p_w_stall = 0;
    forever begin
      @(negedge clk);
      #1;
      ncyc++;
      if (rst) begin
        chk("reset_ctrl", 32'({req_ready, rsp_valid, rsp_write, rsp_err, mem_axi_awvalid, mem_axi_wvalid,
                               mem_axi_bready, mem_axi_arvalid, mem_axi_rready, mem_axi_arprot, mem_axi_awprot,
                               mem_axi_wstrb}), 32'd0);
        chk("reset_data", mem_axi_araddr | mem_axi_awaddr | mem_axi_wdata | rsp_rdata, 32'd0);
        q.delete();
        prev_rst = 1; p_ar_stall = 0; p_aw_stall = 0; p_w_stall = 0;
      end else begin
        chk("req_ready", 32'(req_ready), prev_rst ? 32'd0 : 32'(q.size() == 0));
        if (mem_axi_arvalid) begin
          chk("araddr", mem_axi_araddr, cur_addr);
          chk("arprot", 32'(mem_axi_arprot), 32'({cur_insn, 2'b00}));
          if (t_ar < 0) begin t_ar = ncyc; last_arprot = mem_axi_arprot; end
        end
        if (mem_axi_awvalid) begin
          chk("awaddr", mem_axi_awaddr, cur_addr);
          chk("awprot", 32'(mem_axi_awprot), 32'd0);
          t_aw_last = ncyc;
        end
        if (mem_axi_wvalid) begin
          chk("wdata", mem_axi_wdata, cur_wdata);
          chk("wstrb", 32'(mem_axi_wstrb), 32'(cur_strb));
          t_w_last = ncyc;
        end
        if (mem_axi_rready && t_rr < 0) t_rr = ncyc;
        if (mem_axi_bready) begin
          if (t_b < 0) t_b = ncyc;
          t_b_last = ncyc;
        end
        if (!expect_tmo) begin
          if (p_ar_stall) chk("arvalid_hold", 32'(mem_axi_arvalid), 32'd1);
          if (p_aw_stall) chk("awvalid_hold", 32'(mem_axi_awvalid), 32'd1);
          if (p_w_stall)  chk("wvalid_hold", 32'(mem_axi_wvalid), 32'd1);
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            chk("rsp_write", 32'(rsp_write), 32'(q[0].w));
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
            chk("rsp_rdata", rsp_rdata, q[0].rdata);
            if (t_rsp < 0) t_rsp = ncyc;
            rsp_cycles++;
            if (rsp_ready) begin
              last_rdata = rsp_rdata; last_write = rsp_write; last_err = rsp_err;
              void'(q.pop_front());
            end
          end
        end
        if (req_valid && req_ready) begin
          e.w = req_write;
          e.err = expect_tmo;
          if (expect_tmo)     e.rdata = 32'hDEAD_BEEF;
          else if (req_write) e.rdata = 32'd0;
          else                e.rdata = mmem.exists(req_addr) ? mmem[req_addr] : init_word(req_addr);
          if (req_write && !expect_tmo) begin
            old = mmem.exists(req_addr) ? mmem[req_addr] : init_word(req_addr);
            mmem[req_addr] = merge(old, req_wdata, req_wstrb);
          end
          q.push_back(e);
          cur_addr = req_addr; cur_wdata = req_wdata; cur_strb = req_wstrb; cur_insn = req_insn;
          t_acc = ncyc; t_ar = -1; t_rr = -1; t_aw_last = -1; t_w_last = -1; t_b = -1; t_b_last = -1;
          t_rsp = -1; rsp_cycles = 0;
        end
        prev_rst = 0;
        p_ar_stall = mem_axi_arvalid && !mem_axi_arready;
        p_aw_stall = mem_axi_awvalid && !mem_axi_awready;
        p_w_stall  = mem_axi_wvalid && !mem_axi_wready;
      end
    end
  end

  // One request, then hold rsp_ready low for 'hold' response cycles
  task automatic xfer(input bit w, input bit insn, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold);
    int guard;
    int h;
    h = hold;
    @(negedge clk);
    req_valid = 1; req_write = w; req_insn = insn; req_addr = a; req_wdata = d; req_wstrb = s;
    rsp_ready = (h == 0);
    guard = 0;
    while (!req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) chk("accept_bound", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom); req_wstrb = 4'($urandom);
    guard = 0;
    forever begin
      if (rsp_valid) begin
        if (h > 0) begin rsp_ready = 0; h--; end
        else begin rsp_ready = 1; break; end
      end
      @(negedge clk);
      guard++;
      if (guard > 500) begin chk("rsp_bound", 32'(rsp_valid), 32'd1); break; end
    end
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bit          w;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 0;
    @(negedge clk); #2 chk("req_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk); #2 chk("req_ready_after_edge", 32'(req_ready), 32'd1);

    // Zero-wait read
    rmem[32'h100] = 32'h1234_5678;
    mmem[32'h100] = 32'h1234_5678;
    xfer(0, 0, 32'h100, 32'd0, 4'd0, 0);
    chk("rd_ar_lat", 32'(t_ar - t_acc), 32'd1);
    chk("rd_rready_lat", 32'(t_rr - t_acc), 32'd2);
    chk("rd_rsp_lat", 32'(t_rsp - t_acc), 32'd3);
    chk("rd_rdata_lit", last_rdata, 32'h1234_5678);
    chk("rd_write_lit", 32'(last_write), 32'd0);
    chk("rd_arprot_lit", 32'(last_arprot), 32'd0);

    // Write with slow W channel, then read back the strobe-merged word
    aw_dly = 0; w_dly = 3;
    xfer(1, 0, 32'h200, 32'hA5A5_A5A5, 4'b0101, 0);
    chk("wr_aw_last", 32'(t_aw_last - t_acc), 32'd1);
    chk("wr_w_last", 32'(t_w_last - t_acc), 32'd4);
    chk("wr_bready", 32'(t_b - t_acc), 32'd5);
    chk("wr_rsp_lat", 32'(t_rsp - t_acc), 32'd6);
    chk("wr_write_lit", 32'(last_write), 32'd1);
    w_dly = 0;
    xfer(0, 0, 32'h200, 32'd0, 4'd0, 0);
    chk("wr_merge_lit", last_rdata, 32'hC0A5_02A5);

    // Instruction fetch with a stalled response consumer
    xfer(0, 1, 32'h300, 32'd0, 4'd0, 5);
    chk("insn_arprot_lit", 32'(last_arprot), 32'd4);
    chk("insn_rsp_cycles", 32'(rsp_cycles), 32'd6);
    chk("insn_rdata_lit", last_rdata, 32'hC0DE_0300);

    // Reset while AR is stalled
    ar_dly = 20;
    @(negedge clk);
    chk("rst_test_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = 0; req_insn = 0; req_addr = 32'h100;
    @(negedge clk); req_valid = 0;
    @(negedge clk); #2 chk("rst_test_arvalid_pre", 32'(mem_axi_arvalid), 32'd1);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("rst_async_arvalid", 32'(mem_axi_arvalid), 32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    ar_dly = 0;
    @(posedge clk); #2 rst = 0;
    xfer(0, 0, 32'h100, 32'd0, 4'd0, 0);
    chk("post_rst_rdata_lit", last_rdata, 32'h1234_5678);
    chk("post_rst_rsp_lat", 32'(t_rsp - t_acc), 32'd3);

    // Random back-to-back traffic with random responder delays
    rand_dly = 1;
    for (int i = 0; i < 100; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      xfer(w, w ? 1'b0 : 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)));
    end
    rand_dly = 0;

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
    // Responder never answers B
    b_never = 1; expect_tmo = 1;
    xfer(1, 0, 32'h8000, 32'h0000_0001, 4'hF, 0);
    chk("tmo_rsp_lat", 32'(t_rsp - t_acc), 32'(TMO + 1));
    chk("tmo_bready_last", 32'(t_b_last - t_acc), 32'(TMO));
    chk("tmo_err_lit", 32'(last_err), 32'd1);
    chk("tmo_rdata_lit", last_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    expect_tmo = 0; b_never = 0;
    @(posedge clk); #2 rst = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 0;
    xfer(0, 0, 32'h100, 32'd0, 4'd0, 0);
    chk("post_tmo_rdata_lit", last_rdata, 32'h1234_5678);
`endif

    @(negedge clk); #2;
    chk("no_lost_rsp", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
